// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: parity modes, FSM state encoding and a frame-length helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    function automatic int frame_len(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter; refuses pushes when full and pops when empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_baud,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_baud) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input into a DEPTH-word FIFO, one line bit per clk_baud.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = PAR_EVEN,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 1,
    parameter int DEPTH     = 4
) (
    input  logic                       clk_baud,
    input  logic                       rst,
    input  logic                       tx_valid,
    input  logic [DATA_W-1:0]          tx_data,
    output logic                       tx_ready,
    output logic                       serial_out,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CNT_W = $clog2(DATA_W);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W=%0d outside 5..9", DATA_W);
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_param: PARITY=%0d outside 0..2", PARITY);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS=%0d outside 1..2", STOP_BITS);
    end
    if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_order
        $error("uart_tx_param: MSB_FIRST=%0d must be 0 or 1", MSB_FIRST);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  bit_cnt;
    logic              stop_cnt;
    logic              par_bit;
    logic              next_bit;
    logic              fifo_full;
    logic              fifo_empty;
    logic              last_stop;
    logic              pop;

    uart_tx_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_baud (clk_baud),
        .rst      (rst),
        .push     (tx_valid),
        .push_data(tx_data),
        .pop      (pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign tx_ready  = !fifo_full;
    assign last_stop = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));
    assign pop       = !fifo_empty && ((state == IDLE) || last_stop);

    if (MSB_FIRST != 0) begin : g_msb_first
        assign next_bit   = shreg[DATA_W-1];
        assign shreg_next = {shreg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
        assign next_bit   = shreg[0];
        assign shreg_next = {1'b0, shreg[DATA_W-1:1]};
    end

    // A pop (from IDLE or the last stop bit) always starts a new frame, so it overrides the case.
    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else if (pop) begin
            shreg      <= head;
            par_bit    <= (PARITY == PAR_ODD) ? ~^head : ^head;
            state      <= START;
            serial_out <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                START: begin
                    state      <= DATA;
                    serial_out <= next_bit;
                    shreg      <= shreg_next;
                    bit_cnt    <= '0;
                end
                DATA: begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state      <= PAR;
                            serial_out <= par_bit;
                        end else begin
                            state      <= STOP;
                            serial_out <= 1'b1;
                            stop_cnt   <= 1'b0;
                        end
                    end else begin
                        bit_cnt    <= bit_cnt + CNT_W'(1);
                        serial_out <= next_bit;
                        shreg      <= shreg_next;
                    end
                end
                PAR: begin
                    state      <= STOP;
                    serial_out <= 1'b1;
                    stop_cnt   <= 1'b0;
                end
                STOP: begin
                    if (last_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
